// File: rtl/axil_memory_arbiter.sv
// axil_memory_arbiter: two-master round-robin AXI-Lite arbiter in front of a single-port memory
module axil_memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
    input  logic [2:0]            s0_axil_awprot,
    input  logic                  s0_axil_awvalid,
    output logic                  s0_axil_awready,
    input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
    input  logic                  s0_axil_wvalid,
    output logic                  s0_axil_wready,
    output logic                  s0_axil_bvalid,
    input  logic                  s0_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
    input  logic [2:0]            s0_axil_arprot,
    input  logic                  s0_axil_arvalid,
    output logic                  s0_axil_arready,
    output logic [DATA_WIDTH-1:0] s0_axil_rdata,
    output logic [1:0]            s0_axil_rresp,
    output logic                  s0_axil_rvalid,
    input  logic                  s0_axil_rready,
    input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
    input  logic [2:0]            s1_axil_awprot,
    input  logic                  s1_axil_awvalid,
    output logic                  s1_axil_awready,
    input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
    input  logic                  s1_axil_wvalid,
    output logic                  s1_axil_wready,
    output logic                  s1_axil_bvalid,
    input  logic                  s1_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
    input  logic [2:0]            s1_axil_arprot,
    input  logic                  s1_axil_arvalid,
    output logic                  s1_axil_arready,
    output logic [DATA_WIDTH-1:0] s1_axil_rdata,
    output logic [1:0]            s1_axil_rresp,
    output logic                  s1_axil_rvalid,
    input  logic                  s1_axil_rready,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);
    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_DATA} r_state_t;
    w_state_t w_state;
    r_state_t r_state;
    logic w_grant, w_ptr, aw_done, w_done, r_grant, r_ptr;
    logic w_req0, w_req1, r_req0, r_req1;
    logic w_fwd, w_resp, r_fwd, r_data;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign w_req0 = s0_axil_awvalid | s0_axil_wvalid;
    assign w_req1 = s1_axil_awvalid | s1_axil_wvalid;
    assign r_req0 = s0_axil_arvalid;
    assign r_req1 = s1_axil_arvalid;
    assign w_fwd  = w_state == W_FWD;
    assign w_resp = w_state == W_RESP;
    assign r_fwd  = r_state == R_FWD;
    assign r_data = r_state == R_DATA;
    assign m_axil_awaddr  = w_grant ? s1_axil_awaddr : s0_axil_awaddr;
    assign m_axil_awprot  = w_grant ? s1_axil_awprot : s0_axil_awprot;
    assign m_axil_awvalid = w_fwd & !aw_done & (w_grant ? s1_axil_awvalid : s0_axil_awvalid);
    assign s0_axil_awready = w_fwd & !w_grant & !aw_done & m_axil_awready;
    assign s1_axil_awready = w_fwd & w_grant & !aw_done & m_axil_awready;
    assign m_axil_wdata   = w_grant ? s1_axil_wdata : s0_axil_wdata;
    assign m_axil_wstrb   = w_grant ? s1_axil_wstrb : s0_axil_wstrb;
    assign m_axil_wvalid  = w_fwd & !w_done & (w_grant ? s1_axil_wvalid : s0_axil_wvalid);
    assign s0_axil_wready = w_fwd & !w_grant & !w_done & m_axil_wready;
    assign s1_axil_wready = w_fwd & w_grant & !w_done & m_axil_wready;
    assign m_axil_bready  = w_resp & (w_grant ? s1_axil_bready : s0_axil_bready);
    assign s0_axil_bvalid = w_resp & !w_grant & m_axil_bvalid;
    assign s1_axil_bvalid = w_resp & w_grant & m_axil_bvalid;
    assign m_axil_araddr  = r_grant ? s1_axil_araddr : s0_axil_araddr;
    assign m_axil_arprot  = r_grant ? s1_axil_arprot : s0_axil_arprot;
    assign m_axil_arvalid = r_fwd & (r_grant ? s1_axil_arvalid : s0_axil_arvalid);
    assign s0_axil_arready = r_fwd & !r_grant & m_axil_arready;
    assign s1_axil_arready = r_fwd & r_grant & m_axil_arready;
    assign m_axil_rready  = r_data & (r_grant ? s1_axil_rready : s0_axil_rready);
    assign s0_axil_rvalid = r_data & !r_grant & m_axil_rvalid;
    assign s1_axil_rvalid = r_data & r_grant & m_axil_rvalid;
    assign s0_axil_rdata  = m_axil_rdata;
    assign s1_axil_rdata  = m_axil_rdata;
    assign s0_axil_rresp  = m_axil_rresp;
    assign s1_axil_rresp  = m_axil_rresp;
    assign aw_hs = m_axil_awvalid & m_axil_awready;
    assign w_hs  = m_axil_wvalid & m_axil_wready;
    assign b_hs  = m_axil_bvalid & m_axil_bready;
    assign ar_hs = m_axil_arvalid & m_axil_arready;
    assign r_hs  = m_axil_rvalid & m_axil_rready;
    // ptr names the favoured port on a tie; after a response it points away from the port just served
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            w_grant <= 1'b0;
            w_ptr   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: if (w_req0 | w_req1) begin
                    w_grant <= (w_req0 & w_req1) ? w_ptr : w_req1;
                    w_state <= W_FWD;
                end
                W_FWD: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs) w_done <= 1'b1;
                    if ((aw_done | aw_hs) & (w_done | w_hs)) w_state <= W_RESP;
                end
                W_RESP: if (b_hs) begin
                    w_state <= W_IDLE;
                    w_ptr   <= ~w_grant;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= R_IDLE;
            r_grant <= 1'b0;
            r_ptr   <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: if (r_req0 | r_req1) begin
                    r_grant <= (r_req0 & r_req1) ? r_ptr : r_req1;
                    r_state <= R_FWD;
                end
                R_FWD: if (ar_hs) r_state <= R_DATA;
                R_DATA: if (r_hs) begin
                    r_state <= R_IDLE;
                    r_ptr   <= ~r_grant;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_memory_arbiter.sv
// tb_axil_memory_arbiter: directed vector and sequence checks of the two-master AXI-Lite arbiter
module tb_axil_memory_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
    logic [2:0]  awprot [2], arprot [2];
    logic [3:0]  wstrb [2];
    logic [1:0]  rresp [2];
    logic [1:0]  awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  arvalid, arready, rvalid, rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_rresp;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rready;
    logic [14:0] outs;
    int errors = 0, checks = 0, cyc = 0;
    int ar_hs [2], aw_hs [2], r_hs [2], b_cnt [2];

    axil_memory_arbiter dut (
        .aclk(clk), .areset(rst),
        .s0_axil_awaddr(awaddr[0]), .s0_axil_awprot(awprot[0]), .s0_axil_awvalid(awvalid[0]), .s0_axil_awready(awready[0]),
        .s0_axil_wdata(wdata[0]), .s0_axil_wstrb(wstrb[0]), .s0_axil_wvalid(wvalid[0]), .s0_axil_wready(wready[0]),
        .s0_axil_bvalid(bvalid[0]), .s0_axil_bready(bready[0]),
        .s0_axil_araddr(araddr[0]), .s0_axil_arprot(arprot[0]), .s0_axil_arvalid(arvalid[0]), .s0_axil_arready(arready[0]),
        .s0_axil_rdata(rdata[0]), .s0_axil_rresp(rresp[0]), .s0_axil_rvalid(rvalid[0]), .s0_axil_rready(rready[0]),
        .s1_axil_awaddr(awaddr[1]), .s1_axil_awprot(awprot[1]), .s1_axil_awvalid(awvalid[1]), .s1_axil_awready(awready[1]),
        .s1_axil_wdata(wdata[1]), .s1_axil_wstrb(wstrb[1]), .s1_axil_wvalid(wvalid[1]), .s1_axil_wready(wready[1]),
        .s1_axil_bvalid(bvalid[1]), .s1_axil_bready(bready[1]),
        .s1_axil_araddr(araddr[1]), .s1_axil_arprot(arprot[1]), .s1_axil_arvalid(arvalid[1]), .s1_axil_arready(arready[1]),
        .s1_axil_rdata(rdata[1]), .s1_axil_rresp(rresp[1]), .s1_axil_rvalid(rvalid[1]), .s1_axil_rready(rready[1]),
        .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
        .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
        .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
        .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
        .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
    );

    always #5 clk = ~clk;
    assign outs = {awready, wready, bvalid, arready, rvalid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};

    // memory slave: always ready, one-cycle read latency, B one cycle after both AW and W arrive
    logic [31:0] mem [64];
    logic aw_got, w_got;
    logic [31:0] aw_a, w_d;
    logic [3:0] w_s;
    bit init_done = 1'b0;
    assign m_awready = 1'b1;
    assign m_wready = 1'b1;
    assign m_arready = 1'b1;
    assign m_rresp = 2'b00;
    always @(posedge clk) begin
        if (rst) begin
            m_bvalid <= 1'b0;
            m_rvalid <= 1'b0;
            aw_got <= 1'b0;
            w_got <= 1'b0;
            if (!init_done) begin
                for (int i = 0; i < 64; i++) mem[i] <= (i == 4) ? 32'h11223344 : 32'h0;
                init_done <= 1'b1;
            end
        end else begin
            if (m_awvalid && m_awready) begin aw_got <= 1'b1; aw_a <= m_awaddr; end
            if (m_wvalid && m_wready) begin w_got <= 1'b1; w_d <= m_wdata; w_s <= m_wstrb; end
            if (aw_got && w_got && !m_bvalid) begin
                for (int i = 0; i < 4; i++) if (w_s[i]) mem[aw_a[7:2]][8*i +: 8] <= w_d[8*i +: 8];
                m_bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got <= 1'b0;
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if (m_arvalid && m_arready) begin m_rvalid <= 1'b1; m_rdata <= mem[m_araddr[7:2]]; end
            else if (m_rvalid && m_rready) m_rvalid <= 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc++;
        for (int p = 0; p < 2; p++) begin
            if (arvalid[p] && arready[p]) ar_hs[p] = cyc;
            if (awvalid[p] && awready[p]) aw_hs[p] = cyc;
            if (rvalid[p] && rready[p]) r_hs[p] = cyc;
            if (bvalid[p] && bready[p]) b_cnt[p]++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input int p, input logic [31:0] a);
        araddr[p] = a;
        arvalid[p] = 1'b1;
        for (int i = 0; i < 40 && arvalid[p]; i++) begin
            logic h;
            h = arready[p];
            tick();
            if (h) arvalid[p] = 1'b0;
        end
        chk("ar_accept", {31'b0, arvalid[p]}, 0);
        arvalid[p] = 1'b0;
    endtask

    task automatic rd(input int p, input logic [31:0] a, input logic [31:0] exp, input string name);
        send_ar(p, a);
        for (int i = 0; i < 40 && !rvalid[p]; i++) tick();
        chk({name, "_rvalid"}, {31'b0, rvalid[p]}, 1);
        chk(name, rdata[p], exp);
        tick();
    endtask

    task automatic send_w(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int dly);
        awaddr[p] = a;
        wdata[p] = d;
        wstrb[p] = s;
        wvalid[p] = 1'b1;
        for (int i = 0; i < 60 && (awvalid[p] || wvalid[p] || i <= dly); i++) begin
            logic ha, hw;
            if (i == dly) awvalid[p] = 1'b1;
            ha = awvalid[p] & awready[p];
            hw = wvalid[p] & wready[p];
            tick();
            if (ha) awvalid[p] = 1'b0;
            if (hw) wvalid[p] = 1'b0;
        end
        chk("aw_accept", {31'b0, awvalid[p]}, 0);
        chk("w_accept", {31'b0, wvalid[p]}, 0);
        awvalid[p] = 1'b0;
        wvalid[p] = 1'b0;
    endtask

    task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int dly);
        send_w(p, a, d, s, dly);
        for (int i = 0; i < 40 && !bvalid[p]; i++) tick();
        chk("bvalid", {31'b0, bvalid[p]}, 1);
        tick();
    endtask

    typedef struct {
        bit wr;
        int p;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0] s;
        logic [31:0] e;
    } vec_t;
    vec_t v [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st, bc;
        v[0] = '{1'b1, 0, 32'h00, 32'hA5A5A5A5, 4'hF, 32'h0};
        v[1] = '{1'b0, 1, 32'h00, 32'h0, 4'h0, 32'hA5A5A5A5};
        v[2] = '{1'b1, 1, 32'h04, 32'h12345678, 4'hF, 32'h0};
        v[3] = '{1'b1, 0, 32'h04, 32'h0000FF00, 4'h2, 32'h0};
        v[4] = '{1'b0, 0, 32'h04, 32'h0, 4'h0, 32'h1234FF78};
        v[5] = '{1'b1, 1, 32'h08, 32'hCAFEF00D, 4'h9, 32'h0};
        v[6] = '{1'b0, 1, 32'h08, 32'h0, 4'h0, 32'hCA00000D};
        v[7] = '{1'b0, 0, 32'h0C, 32'h0, 4'h0, 32'h0};
        for (int p = 0; p < 2; p++) begin
            awaddr[p] = 0; wdata[p] = 0; araddr[p] = 0; awprot[p] = 0; arprot[p] = 0; wstrb[p] = 0;
            ar_hs[p] = 0; aw_hs[p] = 0; r_hs[p] = 0; b_cnt[p] = 0;
        end
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 2'b11; rready = 2'b11;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_outs", {17'b0, outs}, 0);
        rst = 1'b0;
        tick();

        // contention: fresh pointer favours s0, then alternation continues s0, s1, s0
        for (int k = 0; k < 2; k++) begin
            fork
                rd(0, 32'h10, 32'h11223344, "cr_s0");
                rd(1, 32'h0C, 32'h0, "cr_s1");
            join
            chk("cr_order", {31'b0, ar_hs[0] < ar_hs[1]}, 1);
            chk("cr_gap", ar_hs[1] - r_hs[0], 2);
        end

        arvalid[0] = 1'b1;
        araddr[0] = 32'h10;
        tick();
        chk("sr_arready", {31'b0, arready[0]}, 1);
        chk("sr_s1_arready", {31'b0, arready[1]}, 0);
        tick();
        arvalid[0] = 1'b0;
        chk("sr_rvalid", {31'b0, rvalid[0]}, 1);
        chk("sr_rdata", rdata[0], 32'h11223344);
        chk("sr_s1_rvalid", {31'b0, rvalid[1]}, 0);
        tick();
        chk("sr_rvalid_done", {31'b0, rvalid[0]}, 0);

        for (int i = 0; i < 8; i++)
            if (v[i].wr) wr(v[i].p, v[i].a, v[i].d, v[i].s, 0);
            else rd(v[i].p, v[i].a, v[i].e, $sformatf("vec%0d", i));

        bc = b_cnt[1];
        wr(1, 32'h20, 32'hDEADBEEF, 4'hF, 3);
        chk("wfirst_bcount", b_cnt[1] - bc, 1);
        rd(0, 32'h20, 32'hDEADBEEF, "wfirst_read");

        st = cyc;
        fork
            rd(0, 32'h10, 32'h11223344, "cc_read");
            wr(1, 32'h24, 32'h0BADF00D, 4'hF, 0);
        join
        chk("cc_ar_time", ar_hs[0] - st, 2);
        chk("cc_aw_time", aw_hs[1] - st, 2);
        rd(1, 32'h24, 32'h0BADF00D, "cc_readback");

        bready[0] = 1'b0;
        send_w(0, 32'h28, 32'h55AA55AA, 4'hF, 0);
        for (int i = 0; i < 40 && !bvalid[0]; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", {31'b0, bvalid[0]}, 1);
            chk("bp_m_bready", {31'b0, m_bready}, 0);
            tick();
        end
        bready[0] = 1'b1;
        #1;
        chk("bp_m_bready_rel", {31'b0, m_bready}, 1);
        tick();
        chk("bp_bvalid_clr", {31'b0, bvalid[0]}, 0);
        rready[0] = 1'b0;
        send_ar(0, 32'h28);
        for (int i = 0; i < 40 && !rvalid[0]; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid", {31'b0, rvalid[0]}, 1);
            chk("bp_m_rready", {31'b0, m_rready}, 0);
            chk("bp_rdata", rdata[0], 32'h55AA55AA);
            tick();
        end
        rready[0] = 1'b1;
        tick();
        chk("bp_rvalid_clr", {31'b0, rvalid[0]}, 0);

        // last write came from s0, so without reset s1 would win the next tie
        awaddr[0] = 32'h30;
        awvalid[0] = 1'b1;
        tick();
        chk("rst_pre_awready", {31'b0, awready[0]}, 1);
        tick();
        awvalid[0] = 1'b0;
        chk("rst_pre_done", {31'b0, awready[0]}, 0);
        rst = 1'b1;
        tick();
        chk("rst_outs", {17'b0, outs}, 0);
        rst = 1'b0;
        tick();
        fork
            wr(0, 32'h30, 32'h00000001, 4'hF, 0);
            wr(1, 32'h34, 32'h00000002, 4'hF, 0);
        join
        chk("rst_ptr", {31'b0, aw_hs[0] < aw_hs[1]}, 1);
        rd(1, 32'h30, 32'h00000001, "rst_read0");
        rd(0, 32'h34, 32'h00000002, "rst_read1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
